// File: rtl/ramio_arbiter_pkg.sv
// ramio_arbiter_pkg: shared types and constants for the two-requester RAMIO arbiter.
package ramio_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  typedef logic req_id_t;
  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;
  localparam logic [1:0] REQ_NONE = 2'b00;
  localparam int PRIORITY_RR = 0;
  localparam int PRIORITY_FIXED = 1;
  localparam int WDOG_W = 21;
  function automatic logic [1:0] grant_onehot(input req_id_t g);
    return g ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/ramio_arbiter_pick.sv
// rr_pick2: combinational two-way picker, round-robin on last_served or fixed r0-first.
module rr_pick2
  import ramio_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_served,
  input  logic       mode,
  output logic       valid,
  output req_id_t    winner
);
  always_comb begin
    valid = |req;
    winner = &req ? (mode ? REQ0 : ~last_served) : req[1];
  end
endmodule

// File: rtl/ramio_arbiter.sv
// ramio_arbiter: grants the single RAMIO port to r0 or r1 one whole transaction at a time.
// Optional grant watchdog enabled by defining RAMIO_ARBITER_WATCHDOG_EN.
module ramio_arbiter
  import ramio_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int PRIORITY_MODE = 0,
  parameter int WATCHDOG_CYCLES = 1_048_576
) (
  input  logic              br_clk_out,
  input  logic              sys_rst_n,
  input  logic              r0_enable,
  input  logic [1:0]        r0_write_type,
  input  logic [2:0]        r0_read_type,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [31:0]       r0_data_in,
  output logic              r0_busy,
  output logic              r0_data_out_ready,
  output logic [31:0]       r0_data_out,
  input  logic              r1_enable,
  input  logic [1:0]        r1_write_type,
  input  logic [2:0]        r1_read_type,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [31:0]       r1_data_in,
  output logic              r1_busy,
  output logic              r1_data_out_ready,
  output logic [31:0]       r1_data_out,
  output logic              ramio_enable,
  output logic [1:0]        ramio_write_type,
  output logic [2:0]        ramio_read_type,
  output logic [ADDR_W-1:0] ramio_address,
  output logic [31:0]       ramio_data_in,
  input  logic              ramio_busy,
  input  logic              ramio_data_out_ready,
  input  logic [31:0]       ramio_data_out,
  output logic [1:0]        arb_grant,
  output logic              arb_timeout
);
  arb_state_t state, state_nx;
  req_id_t grant, grant_nx, last_served, last_nx, pick_winner;
  logic pick_valid, en_g, active, timeout;

  rr_pick2 u_pick (
    .req         ({r1_enable, r0_enable}),
    .last_served (last_served),
    .mode        (PRIORITY_MODE == PRIORITY_FIXED),
    .valid       (pick_valid),
    .winner      (pick_winner)
  );

`ifdef RAMIO_ARBITER_WATCHDOG_EN
  logic [WDOG_W-1:0] wd_cnt;
  logic wd_expired;
  assign wd_expired = wd_cnt == WDOG_W'(WATCHDOG_CYCLES - 1);
  // Counter saturates so an expiry during a RAMIO burst is held until busy drops.
  assign timeout = state == WAIT && wd_expired && !ramio_busy;
  always_ff @(posedge br_clk_out or negedge sys_rst_n)
    if (!sys_rst_n) wd_cnt <= '0;
    else if (state == IDLE) wd_cnt <= '0;
    else if (!wd_expired) wd_cnt <= wd_cnt + 1'b1;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge br_clk_out or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      grant <= REQ0;
      last_served <= REQ1;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      last_served <= last_nx;
    end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    last_nx = last_served;
    active = state != IDLE;
    en_g = grant ? r1_enable : r0_enable;
    unique case (state)
      IDLE: if (pick_valid) begin
        state_nx = ISSUE;
        grant_nx = pick_winner;
      end
      ISSUE: state_nx = WAIT;
      WAIT: if ((!en_g && !ramio_busy) || timeout) begin
        state_nx = IDLE;
        last_nx = grant;
      end
      default: state_nx = IDLE;
    endcase
    ramio_enable = active && en_g && !timeout;
    ramio_write_type = active ? (grant ? r1_write_type : r0_write_type) : '0;
    ramio_read_type = active ? (grant ? r1_read_type : r0_read_type) : '0;
    ramio_address = active ? (grant ? r1_address : r0_address) : '0;
    ramio_data_in = active ? (grant ? r1_data_in : r0_data_in) : '0;
    arb_grant = active ? grant_onehot(grant) : REQ_NONE;
    // ISSUE forces busy so the owner never sees RAMIO's busy-rise gap.
    r0_busy = !active ? ramio_busy : (grant == REQ0 && state == WAIT) ? ramio_busy : 1'b1;
    r1_busy = !active ? ramio_busy : (grant == REQ1 && state == WAIT) ? ramio_busy : 1'b1;
    r0_data_out_ready = state == WAIT && grant == REQ0 && ramio_data_out_ready;
    r1_data_out_ready = state == WAIT && grant == REQ1 && ramio_data_out_ready;
    r0_data_out = ramio_data_out;
    r1_data_out = ramio_data_out;
    arb_timeout = timeout;
  end
endmodule

// File: tb/tb_ramio_arbiter.sv
// tb_ramio_arbiter: cycle-vector table plus transaction scoreboard for ramio_arbiter (RR and fixed).
module tb_ramio_arbiter;
  import ramio_arbiter_pkg::*;
  localparam int AW = 32;
  localparam int N = 35;

  logic br_clk_out = 1'b0;
  logic sys_rst_n = 1'b0;
  logic r0_enable = 0, r1_enable = 0;
  logic [1:0] r0_write_type = 2'b11, r1_write_type = 2'b00;
  logic [2:0] r0_read_type = 3'b000, r1_read_type = 3'b010;
  logic [AW-1:0] r0_address = 32'h4, r1_address = 32'h4;
  logic [31:0] r0_data_in = 32'h0000_4120, r1_data_in = 32'hdead_beef;
  logic ramio_busy = 0, ramio_data_out_ready = 0;
  logic [31:0] ramio_data_out = 32'h0000_4120;

  logic r0_busy, r1_busy, r0_data_out_ready, r1_data_out_ready, ramio_enable, arb_timeout;
  logic [31:0] r0_data_out, r1_data_out, ramio_data_in;
  logic [1:0] ramio_write_type, arb_grant;
  logic [2:0] ramio_read_type;
  logic [AW-1:0] ramio_address;
  logic f_r0_busy, f_r1_busy, f_r0_rdy, f_r1_rdy, f_en, f_timeout;
  logic [31:0] f_r0_dout, f_r1_dout, f_din;
  logic [1:0] f_wt, f_grant;
  logic [2:0] f_rt;
  logic [AW-1:0] f_addr;

  always #10 br_clk_out = ~br_clk_out;

  ramio_arbiter #(.ADDR_W(AW), .PRIORITY_MODE(0)) u_rr (
    .br_clk_out, .sys_rst_n,
    .r0_enable, .r0_write_type, .r0_read_type, .r0_address, .r0_data_in,
    .r0_busy, .r0_data_out_ready, .r0_data_out,
    .r1_enable, .r1_write_type, .r1_read_type, .r1_address, .r1_data_in,
    .r1_busy, .r1_data_out_ready, .r1_data_out,
    .ramio_enable, .ramio_write_type, .ramio_read_type, .ramio_address, .ramio_data_in,
    .ramio_busy, .ramio_data_out_ready, .ramio_data_out,
    .arb_grant, .arb_timeout
  );

  ramio_arbiter #(.ADDR_W(AW), .PRIORITY_MODE(1)) u_fix (
    .br_clk_out, .sys_rst_n,
    .r0_enable, .r0_write_type, .r0_read_type, .r0_address, .r0_data_in,
    .r0_busy(f_r0_busy), .r0_data_out_ready(f_r0_rdy), .r0_data_out(f_r0_dout),
    .r1_enable, .r1_write_type, .r1_read_type, .r1_address, .r1_data_in,
    .r1_busy(f_r1_busy), .r1_data_out_ready(f_r1_rdy), .r1_data_out(f_r1_dout),
    .ramio_enable(f_en), .ramio_write_type(f_wt), .ramio_read_type(f_rt),
    .ramio_address(f_addr), .ramio_data_in(f_din),
    .ramio_busy, .ramio_data_out_ready, .ramio_data_out,
    .arb_grant(f_grant), .arb_timeout(f_timeout)
  );

  typedef struct {
    logic rst, r0, r1, rb, rdy;
    logic [1:0] push;
    logic [7:0] exp;
  } vec_t;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0] d;
    logic [1:0] wt;
    logic [2:0] rt;
  } txn_t;

  localparam txn_t R0_TXN = '{a: 32'h4, d: 32'h0000_4120, wt: 2'b11, rt: 3'b000};
  localparam txn_t R1_TXN = '{a: 32'h4, d: 32'hdead_beef, wt: 2'b00, rt: 3'b010};

  vec_t tbl[N];
  txn_t sb[$];
  int n_cmp = 0, n_bad = 0;

  function automatic vec_t mk(input logic rst, r0, r1, rb, rdy, input logic [1:0] push,
                              input logic en, input logic [1:0] g, input logic b0, b1, d0, d1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.rb = rb; v.rdy = rdy; v.push = push;
    v.exp = {en, g, b0, b1, d0, d1, 1'b0};
    return v;
  endfunction

  task automatic check(input string n, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  initial begin
    logic prev_en;
    txn_t t;
    //            rst r0 r1 rb rdy push  en g     b0 b1 d0 d1
    tbl[0]  = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 0, 2'b00, 0, 2'b00, 1, 1, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 2'b01, 0, 2'b00, 0, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 2'b00, 1, 2'b01, 1, 1, 0, 0);
    tbl[4]  = mk(0, 1, 0, 1, 0, 2'b00, 1, 2'b01, 1, 1, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 2'b00, 1, 2'b01, 0, 1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    tbl[9]  = mk(0, 1, 1, 0, 0, 2'b11, 0, 2'b00, 0, 0, 0, 0);
    tbl[10] = mk(0, 1, 1, 0, 0, 2'b00, 1, 2'b01, 1, 1, 0, 0);
    tbl[11] = mk(0, 0, 1, 0, 0, 2'b00, 0, 2'b01, 0, 1, 0, 0);
    tbl[12] = mk(0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 1, 0, 0, 2'b00, 1, 2'b10, 1, 1, 0, 0);
    tbl[14] = mk(0, 0, 1, 1, 0, 2'b00, 1, 2'b10, 1, 1, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0);
    tbl[16] = mk(0, 0, 1, 0, 0, 2'b10, 0, 2'b00, 0, 0, 0, 0);
    tbl[17] = mk(0, 1, 1, 0, 0, 2'b01, 1, 2'b10, 1, 1, 0, 0);
    tbl[18] = mk(0, 1, 1, 1, 0, 2'b00, 1, 2'b10, 1, 1, 0, 0);
    tbl[19] = mk(0, 1, 1, 0, 1, 2'b00, 1, 2'b10, 1, 0, 0, 1);
    tbl[20] = mk(0, 1, 0, 0, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0);
    tbl[21] = mk(0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    tbl[22] = mk(0, 1, 0, 0, 0, 2'b00, 1, 2'b01, 1, 1, 0, 0);
    tbl[23] = mk(0, 1, 0, 0, 1, 2'b00, 1, 2'b01, 0, 1, 1, 0);
    tbl[24] = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 1, 0, 0);
    tbl[25] = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    tbl[26] = mk(0, 1, 0, 0, 0, 2'b01, 0, 2'b00, 0, 0, 0, 0);
    tbl[27] = mk(0, 1, 0, 0, 0, 2'b00, 1, 2'b01, 1, 1, 0, 0);
    tbl[28] = mk(0, 1, 0, 1, 0, 2'b00, 1, 2'b01, 1, 1, 0, 0);
    tbl[29] = mk(1, 1, 0, 1, 0, 2'b00, 0, 2'b00, 1, 1, 0, 0);
    tbl[30] = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    tbl[31] = mk(0, 0, 1, 0, 0, 2'b10, 0, 2'b00, 0, 0, 0, 0);
    tbl[32] = mk(0, 0, 1, 0, 0, 2'b00, 1, 2'b10, 1, 1, 0, 0);
    tbl[33] = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 1, 0, 0, 0);
    tbl[34] = mk(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0);
    repeat (2) @(negedge br_clk_out);
    prev_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge br_clk_out);
      sys_rst_n = !tbl[i].rst;
      r0_enable = tbl[i].r0;
      r1_enable = tbl[i].r1;
      ramio_busy = tbl[i].rb;
      ramio_data_out_ready = tbl[i].rdy;
      if (tbl[i].push[0]) sb.push_back(R0_TXN);
      if (tbl[i].push[1]) sb.push_back(R1_TXN);
      #1;
      check($sformatf("row%0d", i),
            {ramio_enable, arb_grant, r0_busy, r1_busy, r0_data_out_ready, r1_data_out_ready, arb_timeout},
            tbl[i].exp);
      if (r0_data_out_ready) check($sformatf("r0_dout%0d", i), r0_data_out, 32'h0000_4120);
      if (r1_data_out_ready) check($sformatf("r1_dout%0d", i), r1_data_out, 32'h0000_4120);
      if (ramio_enable && !prev_en) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL txn%0d: got ramio_enable rise expected no transaction", i);
        end else begin
          t = sb.pop_front();
          check($sformatf("txn%0d", i), {ramio_address, ramio_data_in, ramio_write_type, ramio_read_type}, t);
        end
      end
      prev_en = ramio_enable;
    end
    check("sb_empty", 128'(sb.size()), 128'd0);
    // Fixed priority: r0 re-requesting on every release starves r1; RR hands over instead.
    @(negedge br_clk_out);
    sys_rst_n = 0; r0_enable = 0; r1_enable = 0; ramio_busy = 0; ramio_data_out_ready = 0;
    #1 check("fix_rst_grant", f_grant, 2'b00);
    @(negedge br_clk_out);
    sys_rst_n = 1; r0_enable = 1; r1_enable = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge br_clk_out);
      r0_enable = 1;
      #1 check($sformatf("fix_issue%0d", k), f_grant, 2'b01);
      check($sformatf("rr_issue%0d", k), arb_grant, k == 0 ? 2'b01 : 2'b10);
      @(negedge br_clk_out);
      r0_enable = 0;
      @(negedge br_clk_out);
      r0_enable = 1;
      #1 check($sformatf("fix_idle%0d", k), f_grant, 2'b00);
    end
    @(negedge br_clk_out);
    r0_enable = 0;
    repeat (3) @(negedge br_clk_out);
    #1 check("fix_r1_served", f_grant, 2'b10);
    r1_enable = 0;
    repeat (3) @(negedge br_clk_out);
    #1 check("fix_final_idle", f_grant, 2'b00);
    check("rr_final_idle", arb_grant, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
